// File: rtl/xm23_alu_if.sv
// xm23_alu_if: operand/result bundle between the XM23 control/datapath and the ALU.
// master drives operands and op code; slave (the ALU) returns result and PSW.
interface xm23_alu_if;
    logic [15:0] d_in;
    logic [15:0] s_in;
    logic [5:0]  alu_op;
    logic [15:0] psw_in;
    logic        psw_update;
    logic [15:0] alu_out;
    logic [15:0] alu_psw_out;

    modport master (
        output d_in,
        output s_in,
        output alu_op,
        output psw_in,
        output psw_update,
        input  alu_out,
        input  alu_psw_out
    );

    modport slave (
        input  d_in,
        input  s_in,
        input  alu_op,
        input  psw_in,
        input  psw_update,
        output alu_out,
        output alu_psw_out
    );
endinterface

// File: rtl/xm23_alu.sv
// xm23_alu: XM23 arithmetic/logic unit with registered result and PSW (1-cycle latency).
// Optional BCD add (DADD) is built only when XM23_ALU_DADD_EN is defined; otherwise
// DADD is treated like a reserved op code.
module xm23_alu #(
    parameter logic [15:0] PSW_RESET = 16'h60E0
) (
    input logic       Clock,
    input logic       Reset,
    xm23_alu_if.slave bus
);

    localparam logic [4:0] OpAdd  = 5'd0;
    localparam logic [4:0] OpAddc = 5'd1;
    localparam logic [4:0] OpSub  = 5'd2;
    localparam logic [4:0] OpSubc = 5'd3;
    localparam logic [4:0] OpDadd = 5'd4;
    localparam logic [4:0] OpCmp  = 5'd5;
    localparam logic [4:0] OpXor  = 5'd6;
    localparam logic [4:0] OpAnd  = 5'd7;
    localparam logic [4:0] OpOr   = 5'd8;
    localparam logic [4:0] OpBit  = 5'd9;
    localparam logic [4:0] OpBic  = 5'd10;
    localparam logic [4:0] OpBis  = 5'd11;
    localparam logic [4:0] OpMov  = 5'd12;
    localparam logic [4:0] OpSra  = 5'd13;
    localparam logic [4:0] OpRrc  = 5'd14;
    localparam logic [4:0] OpSwpb = 5'd15;
    localparam logic [4:0] OpSxt  = 5'd16;

    logic [15:0] d;
    logic [15:0] s;
    logic [4:0]  op;
    logic        byte_mode;
    logic        c_in;

    assign d         = bus.d_in;
    assign s         = bus.s_in;
    assign op        = bus.alu_op[4:0];
    assign byte_mode = bus.alu_op[5];
    assign c_in      = bus.psw_in[0];

    // In byte mode only the low byte is produced; the high byte passes d through.
    function automatic logic [15:0] merge_byte(input logic bm, input logic [15:0] hi_src,
                                               input logic [15:0] full);
        return bm ? {hi_src[15:8], full[7:0]} : full;
    endfunction

`ifdef XM23_ALU_DADD_EN
    // Nibble-serial BCD add; returns {decimal carry-out, 16-bit result}.
    function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic bm);
        logic [15:0] sum;
        logic [4:0]  t;
        logic        cy;
        logic        byte_cy;
        sum     = '0;
        cy      = cin;
        byte_cy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            t = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]} + {4'd0, cy};
            if (t > 5'd9) begin
                sum[4*k +: 4] = t[3:0] + 4'd6;
                cy            = 1'b1;
            end else begin
                sum[4*k +: 4] = t[3:0];
                cy            = 1'b0;
            end
            if (k == 1) begin
                byte_cy = cy;
            end
        end
        return bm ? {byte_cy, a[15:8], sum[7:0]} : {cy, sum};
    endfunction
`endif

    // Shared adder for ADD/ADDC/SUB/SUBC/CMP; subtraction is d + ~s + carry.
    logic        is_sub;
    logic [15:0] b_opnd;
    logic        add_cin;
    logic [16:0] sum_w;
    logic [8:0]  sum_b;
    logic [15:0] add_res;
    logic        add_c;
    logic        add_v;

    // Adder operand select, carry-in select and byte/word carry/overflow extraction.
    always_comb begin
        is_sub  = (op == OpSub) || (op == OpSubc) || (op == OpCmp);
        b_opnd  = is_sub ? ~s : s;
        add_cin = 1'b0;
        if ((op == OpAddc) || (op == OpSubc)) begin
            add_cin = c_in;
        end else if (is_sub) begin
            add_cin = 1'b1;
        end
        sum_w = {1'b0, d} + {1'b0, b_opnd} + {16'd0, add_cin};
        sum_b = {1'b0, d[7:0]} + {1'b0, b_opnd[7:0]} + {8'd0, add_cin};
        if (byte_mode) begin
            add_res = {d[15:8], sum_b[7:0]};
            add_c   = sum_b[8];
            add_v   = (d[7] == b_opnd[7]) && (sum_b[7] != d[7]);
        end else begin
            add_res = sum_w[15:0];
            add_c   = sum_w[16];
            add_v   = (d[15] == b_opnd[15]) && (sum_w[15] != d[15]);
        end
    end

`ifdef XM23_ALU_DADD_EN
    logic [16:0] bcd_res;
    assign bcd_res = bcd_add(d, s, c_in, byte_mode);
`endif

    logic [15:0] alu_out_d;
    logic [15:0] alu_out_q;
    logic [15:0] psw_d;
    logic [15:0] psw_q;
    logic [15:0] flag_val;
    logic        upd_zn;
    logic        word_only;
    logic        c_d;
    logic        z_d;
    logic        n_d;
    logic        v_d;

    // Operation decode: result, carry/overflow, and the value Z/N are taken from.
    always_comb begin
        alu_out_d = d;
        flag_val  = d;
        upd_zn    = 1'b0;
        word_only = 1'b0;
        c_d       = bus.psw_in[0];
        z_d       = bus.psw_in[1];
        n_d       = bus.psw_in[2];
        v_d       = bus.psw_in[4];

        case (op)
            OpAdd, OpAddc, OpSub, OpSubc: begin
                alu_out_d = add_res;
                flag_val  = add_res;
                c_d       = add_c;
                v_d       = add_v;
                upd_zn    = 1'b1;
            end
            OpCmp: begin
                flag_val = add_res;
                c_d      = add_c;
                v_d      = add_v;
                upd_zn   = 1'b1;
            end
`ifdef XM23_ALU_DADD_EN
            OpDadd: begin
                alu_out_d = bcd_res[15:0];
                flag_val  = bcd_res[15:0];
                c_d       = bcd_res[16];
                upd_zn    = 1'b1;
            end
`endif
            OpXor: begin
                alu_out_d = merge_byte(byte_mode, d, d ^ s);
                flag_val  = alu_out_d;
                upd_zn    = 1'b1;
            end
            OpAnd: begin
                alu_out_d = merge_byte(byte_mode, d, d & s);
                flag_val  = alu_out_d;
                upd_zn    = 1'b1;
            end
            OpOr: begin
                alu_out_d = merge_byte(byte_mode, d, d | s);
                flag_val  = alu_out_d;
                upd_zn    = 1'b1;
            end
            OpBit: begin
                flag_val = d & s;
                upd_zn   = 1'b1;
            end
            OpBic: begin
                alu_out_d = merge_byte(byte_mode, d, d & ~s);
                flag_val  = alu_out_d;
                upd_zn    = 1'b1;
            end
            OpBis: begin
                alu_out_d = merge_byte(byte_mode, d, d | s);
                flag_val  = alu_out_d;
                upd_zn    = 1'b1;
            end
            OpMov: begin
                alu_out_d = merge_byte(byte_mode, d, s);
            end
            OpSra: begin
                alu_out_d = byte_mode ? {d[15:8], d[7], d[7:1]} : {d[15], d[15:1]};
                flag_val  = alu_out_d;
                c_d       = d[0];
                upd_zn    = 1'b1;
            end
            OpRrc: begin
                alu_out_d = byte_mode ? {d[15:8], c_in, d[7:1]} : {c_in, d[15:1]};
                flag_val  = alu_out_d;
                c_d       = d[0];
                upd_zn    = 1'b1;
            end
            OpSwpb: begin
                alu_out_d = {d[7:0], d[15:8]};
                flag_val  = alu_out_d;
                word_only = 1'b1;
                upd_zn    = 1'b1;
            end
            OpSxt: begin
                alu_out_d = {{8{d[7]}}, d[7:0]};
                flag_val  = alu_out_d;
                word_only = 1'b1;
                upd_zn    = 1'b1;
            end
            default: begin
                // Reserved (and DADD when not built): result = d, flags untouched.
            end
        endcase

        if (upd_zn) begin
            if (byte_mode && !word_only) begin
                z_d = (flag_val[7:0] == 8'h00);
                n_d = flag_val[7];
            end else begin
                z_d = (flag_val == 16'h0000);
                n_d = flag_val[15];
            end
        end
    end

    // Next PSW: flags are merged only when the control unit asks for an update.
    always_comb begin
        psw_d = bus.psw_in;
        if (bus.psw_update) begin
            psw_d = {bus.psw_in[15:5], v_d, bus.psw_in[3], n_d, z_d, c_d};
        end
    end

    // Output registers; synchronous reset has priority over any operation.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            alu_out_q <= 16'h0000;
            psw_q     <= PSW_RESET;
        end else begin
            alu_out_q <= alu_out_d;
            psw_q     <= psw_d;
        end
    end

    assign bus.alu_out     = alu_out_q;
    assign bus.alu_psw_out = psw_q;

endmodule

// File: tb/tb_xm23_alu.sv
// tb_xm23_alu: directed and random checks of xm23_alu against an arithmetic reference model.
module tb_xm23_alu;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    xm23_alu_if bus ();

    xm23_alu #(
        .PSW_RESET(16'h60E0)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer arithmetic over the active width (8 or 16 bits).
    function automatic void ref_alu(input logic [15:0] d, input logic [15:0] s,
                                    input logic [5:0] op, input logic [15:0] psw,
                                    input logic upd, output logic [15:0] res,
                                    output logic [15:0] pso);
        int w, mask, ud, us, r, sd, ss, sr, ci, code, maxv, minv;
        bit c, z, n, v, zn, keep_d;
        code   = int'(op[4:0]);
        c      = psw[0];
        z      = psw[1];
        n      = psw[2];
        v      = psw[4];
        zn     = 1'b0;
        keep_d = 1'b0;
        w      = (op[5] && code != 15 && code != 16) ? 8 : 16;
        mask   = (1 << w) - 1;
        maxv   = (1 << (w - 1)) - 1;
        minv   = -(1 << (w - 1));
        ud     = int'(d) & mask;
        us     = int'(s) & mask;
        sd     = (ud > maxv) ? ud - (1 << w) : ud;
        ss     = (us > maxv) ? us - (1 << w) : us;
        r      = ud;
        case (code)
            0, 1: begin
                ci = (code == 1) ? int'(psw[0]) : 0;
                r  = ud + us + ci;
                c  = (r > mask);
                sr = sd + ss + ci;
                v  = (sr > maxv) || (sr < minv);
                zn = 1'b1;
            end
            2, 3, 5: begin
                ci     = (code == 3) ? int'(psw[0]) : 1;
                r      = ud - us - 1 + ci;
                c      = (r >= 0);
                sr     = sd - ss - 1 + ci;
                v      = (sr > maxv) || (sr < minv);
                zn     = 1'b1;
                keep_d = (code == 5);
            end
            4: begin
`ifdef XM23_ALU_DADD_EN
                int cy, t;
                cy = int'(psw[0]);
                r  = 0;
                for (int k = 0; k < w / 4; k++) begin
                    t = ((ud >> (4 * k)) & 15) + ((us >> (4 * k)) & 15) + cy;
                    if (t > 9) begin
                        t  = t + 6;
                        cy = 1;
                    end else begin
                        cy = 0;
                    end
                    r = r | ((t & 15) << (4 * k));
                end
                c  = (cy != 0);
                zn = 1'b1;
`else
                keep_d = 1'b1;
`endif
            end
            6:  begin r = ud ^ us;  zn = 1'b1; end
            7:  begin r = ud & us;  zn = 1'b1; end
            8:  begin r = ud | us;  zn = 1'b1; end
            9:  begin r = ud & us;  zn = 1'b1; keep_d = 1'b1; end
            10: begin r = ud & ~us; zn = 1'b1; end
            11: begin r = ud | us;  zn = 1'b1; end
            12: begin r = us; end
            13: begin
                c  = (ud & 1) != 0;
                r  = (ud >> 1) | (ud & (1 << (w - 1)));
                zn = 1'b1;
            end
            14: begin
                c  = (ud & 1) != 0;
                r  = (ud >> 1) | (int'(psw[0]) << (w - 1));
                zn = 1'b1;
            end
            15: begin r = ((ud & 255) << 8) | (ud >> 8); zn = 1'b1; end
            16: begin r = ((ud & 128) != 0) ? ((ud & 255) | 'hFF00) : (ud & 255); zn = 1'b1; end
            default: keep_d = 1'b1;
        endcase
        r = r & mask;
        if (zn) begin
            z = (r == 0);
            n = ((r >> (w - 1)) & 1) != 0;
        end
        if (keep_d) res = d;
        else if (w == 8) res = {d[15:8], 8'(r)};
        else res = 16'(r);
        pso = psw;
        if (upd) begin
            pso[0] = c;
            pso[1] = z;
            pso[2] = n;
            pso[4] = v;
        end
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] d, input logic [15:0] s, input logic [5:0] op,
                         input logic [15:0] psw, input logic upd);
        bus.d_in       = d;
        bus.s_in       = s;
        bus.alu_op     = op;
        bus.psw_in     = psw;
        bus.psw_update = upd;
    endtask

    task automatic run_step(input string tag, input logic [15:0] d, input logic [15:0] s,
                            input logic [5:0] op, input logic [15:0] psw, input logic upd);
        logic [15:0] er, ep;
        drive(d, s, op, psw, upd);
        @(posedge clk);
        #1;
        ref_alu(d, s, op, psw, upd, er, ep);
        check({tag, " out"}, bus.alu_out, er);
        check({tag, " psw"}, bus.alu_psw_out, ep);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(16'h1234, 16'h5678, 6'h00, 16'h0000, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("reset out", bus.alu_out, 16'h0000);
        check("reset psw", bus.alu_psw_out, 16'h60E0);
        rst = 1'b0;

        run_step("add_ovf", 16'h7FFF, 16'h0001, 6'h00, 16'h60E0, 1'b1);
        check("add_ovf const out", bus.alu_out, 16'h8000);
        check("add_ovf const psw", bus.alu_psw_out, 16'h60F4);

        run_step("sub_byte", 16'h1234, 16'h0034, 6'h22, 16'h60E0, 1'b1);
        check("sub_byte const out", bus.alu_out, 16'h1200);
        check("sub_byte const psw", bus.alu_psw_out, 16'h60E3);

        run_step("rrc", 16'h0001, 16'h0000, 6'h0E, 16'h60E1, 1'b1);
        check("rrc const out", bus.alu_out, 16'h8000);
        check("rrc const psw", bus.alu_psw_out, 16'h60E5);

        run_step("add_noupd", 16'hFFFF, 16'h0001, 6'h00, 16'h60E0, 1'b0);
        check("add_noupd const out", bus.alu_out, 16'h0000);
        check("add_noupd const psw", bus.alu_psw_out, 16'h60E0);

        run_step("add_wrap", 16'hFFFF, 16'h0001, 6'h00, 16'h60E0, 1'b1);
        check("add_wrap const psw", bus.alu_psw_out, 16'h60E3);

        run_step("sub_min", 16'h8000, 16'h0001, 6'h02, 16'h60E0, 1'b1);
        check("sub_min const out", bus.alu_out, 16'h7FFF);
        check("sub_min const psw", bus.alu_psw_out, 16'h60F1);

        run_step("sra_min", 16'h8000, 16'h0000, 6'h0D, 16'h60E0, 1'b1);
        check("sra_min const out", bus.alu_out, 16'hC000);
        check("sra_min const psw", bus.alu_psw_out, 16'h60E4);

        run_step("reserved", 16'hBEEF, 16'h1111, 6'h35, 16'hABCD, 1'b1);
        check("reserved const psw", bus.alu_psw_out, 16'hABCD);

        run_step("dadd", 16'h0199, 16'h0001, 6'h04, 16'h60E0, 1'b1);
`ifdef XM23_ALU_DADD_EN
        check("dadd const out", bus.alu_out, 16'h0200);
`else
        check("dadd const out", bus.alu_out, 16'h0199);
`endif
        check("dadd const psw", bus.alu_psw_out, 16'h60E0);

        // Reset asserted while an ADD is presented, then released.
        drive(16'h1111, 16'h2222, 6'h00, 16'h60E0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset out", bus.alu_out, 16'h0000);
        check("midreset psw", bus.alu_psw_out, 16'h60E0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("resume out", bus.alu_out, 16'h3333);
        check("resume psw", bus.alu_psw_out, 16'h60E0);

        for (int i = 0; i < 400; i++) begin
            run_step($sformatf("rnd%0d", i), 16'($urandom), 16'($urandom),
                     6'($urandom_range(0, 63)), 16'($urandom),
                     ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xm23_alu.md
Name: xm23_alu

Overview:
- Arithmetic/logic unit of the XM23 CPU datapath.
- Computes one operation on the destination-register operand (d) and source operand (s), selected by the 6-bit op code from the control unit.
- Produces the result, which goes to the register file or MDR, and an updated PSW, which goes to psw_in.
- Both outputs are registered, with 1-cycle latency.

Parameters:
- PSW_RESET, 16'h60E0, value loaded into alu_psw_out on reset.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- d_in  in  16  destination operand (d_bus).
- s_in  in  16  source operand (s_bus; register or sign-extended constant).
- alu_op  in  6  bit 5 is W/B (1 = byte); bits 4:0 are the operation.
- psw_in  in  16  current PSW.
- psw_update  in  1  1 = write computed flags; 0 = pass psw_in through.
- alu_out  out  16  registered result.
- alu_psw_out  out  16  registered PSW.

Behaviour:
- Reset (synchronous, active-high): on a rising edge with Reset=1, alu_out=16'h0000 and alu_psw_out=PSW_RESET. Reset wins over any operation.
- Otherwise, on each rising edge both outputs load the combinational result of the current inputs. There is no handshake; a new op is accepted every cycle.
- PSW flag bits: C=bit0, Z=bit1, N=bit2, V=bit4. All other PSW bits (SLP, priorities, FLT) are always copied from psw_in.
- Byte mode (alu_op[5]=1):
  - Operate on bits 7:0 only; alu_out[15:8] = d_in[15:8].
  - C is taken from bit 7 carry-out; N = result bit 7; V from byte signs.
- Word mode: full 16 bits; C from bit 15 carry-out.
- Z is set when the (byte/word) result is zero. N = MSB of the result.
- Operations (alu_op[4:0]):
  - 0 ADD: d+s. Updates C,Z,N,V.
  - 1 ADDC: d+s+C. Updates C,Z,N,V.
  - 2 SUB: d+~s+1. Updates C,Z,N,V; C=1 means no borrow.
  - 3 SUBC: d+~s+C. Updates C,Z,N,V.
  - 4 DADD: BCD add with C carry-in. See Optional Feature.
  - 5 CMP: flags as SUB; alu_out = d unchanged.
  - 6 XOR, 7 AND, 8 OR: updates Z,N; C,V unchanged.
  - 9 BIT: flags of d&s; alu_out = d.
  - 10 BIC: d&~s. Updates Z,N.
  - 11 BIS: d|s. Updates Z,N.
  - 12 MOV: result = s; no flag change.
  - 13 SRA: arithmetic right shift by 1; C = old bit0; updates Z,N.
  - 14 RRC: rotate right through C; new MSB = old C; C = old bit0; updates Z,N.
  - 15 SWPB: swap bytes; word only, W/B ignored; updates Z,N.
  - 16 SXT: sign-extend bit 7 to 16 bits; word only; updates Z,N.
  - 17..31: reserved; result = d, flags unchanged.
- V on signed overflow:
  - ADD/ADDC: operand signs equal and result sign differs.
  - SUB/SUBC/CMP: d and s signs differ and the result sign differs from d.
- psw_update=0: alu_psw_out = psw_in, whatever the op. alu_out is still computed.
- Boundaries:
  - 16'hFFFF+1 gives 0 with C=1, Z=1.
  - 16'h8000-1 gives 16'h7FFF with V=1.
  - 16'h8000 SRA gives 16'hC000.
  - Reserved op codes never alter the PSW.

Optional Feature:
- Macro: XM23_ALU_DADD_EN.
- Defined: DADD adds nibble-wise in BCD, starting with carry-in C. A nibble sum above 9 gets +6 and carries into the next nibble. C = decimal carry-out of the top nibble (bit 7 byte, bit 15 word). Updates Z,N; V unchanged.
- Undefined: DADD behaves as a reserved op (alu_out = d, flags unchanged). No BCD logic is synthesized.

Test Plan:
- Word ADD, d=16'h7FFF, s=16'h0001, psw_in=16'h60E0, psw_update=1 -> alu_out=16'h8000, alu_psw_out=16'h60F4 (N,V set) after one edge.
- Byte SUB (alu_op[5]=1), d=16'h1234, s=16'h0034 -> alu_out=16'h1200, alu_psw_out=16'h60E3 (Z,C).
- Word RRC, d=16'h0001, psw_in=16'h60E1 -> alu_out=16'h8000, alu_psw_out=16'h60E5.
- ADD 16'hFFFF+16'h0001 with psw_update=0, psw_in=16'h60E0 -> alu_out=16'h0000, alu_psw_out=16'h60E0.
- DADD word (macro defined), d=16'h0199, s=16'h0001, C=0 -> alu_out=16'h0200, alu_psw_out=16'h60E0. Without the macro -> alu_out=16'h0199.
- Assert Reset during a running ADD -> next edge alu_out=16'h0000, alu_psw_out=16'h60E0. Operation resumes the cycle after Reset drops.
